// File: rtl/key_command_frontend.sv
// Pushbutton front end: sync + debounce of four active-low keys, press pulses for
// keys 0..2, short/long press decode on key 3. Optional macro: KEY_SPEED_SATURATE_EN.

module key_command_frontend_debounce #(
  parameter int CYCLES = 4,
  parameter int CNT_W  = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key_n,
  output logic o_level
);
  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sample;

  // Working polarity is 1 = pressed.
  assign sample  = ~sync2_q;
  assign o_level = level_q;

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sample != level_q) begin
      if (cnt_q == CNT_W'(CYCLES - 1)) begin
        level_d = sample;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= i_key_n;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

module key_command_frontend #(
  parameter int DEBOUNCE_CYCLES  = 500000,
  parameter int LONGPRESS_CYCLES = 50000000,
  parameter int SPEED_MAX        = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [3:0] i_key_n,
  output logic [2:0] o_key_pulse,
  output logic [3:0] o_speed,
  output logic       o_fast,
  output logic       o_slow_0,
  output logic       o_slow_1,
  output logic       o_cfg_change
);
  localparam int DB_W   = (DEBOUNCE_CYCLES  > 1) ? $clog2(DEBOUNCE_CYCLES)  : 1;
  localparam int HOLD_W = (LONGPRESS_CYCLES > 1) ? $clog2(LONGPRESS_CYCLES) : 1;
  localparam logic [3:0] SPD_MAX = 4'(SPEED_MAX);

  typedef enum logic [1:0] {K_IDLE, K_HOLD, K_WAIT} kstate_t;

  logic [3:0]        db;
  logic [2:0]        db_prev_q, db_prev_d;
  logic [2:0]        pulse_q, pulse_d;
  kstate_t           state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [3:0]        speed_q, speed_d;
  // One-hot {slow1, slow0, fast}; all zero is NORMAL. Kept as flops so outputs never glitch.
  logic [2:0]        mode_q, mode_d;
  logic              cfg_q, cfg_d;
  logic              short_ev, long_ev;

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_key
      key_command_frontend_debounce #(
        .CYCLES (DEBOUNCE_CYCLES),
        .CNT_W  (DB_W)
      ) u_db (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_key_n (i_key_n[g]),
        .o_level (db[g])
      );
    end
  endgenerate

  always_comb begin
    db_prev_d = db[2:0];
    pulse_d   = db[2:0] & ~db_prev_q;
  end

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    short_ev = 1'b0;
    long_ev  = 1'b0;
    case (state_q)
      K_IDLE: begin
        if (db[3]) begin
          state_d = K_HOLD;
          hold_d  = '0;
        end
      end
      K_HOLD: begin
        if (!db[3]) begin
          short_ev = 1'b1;
          state_d  = K_IDLE;
        end else if (hold_q == HOLD_W'(LONGPRESS_CYCLES - 1)) begin
          long_ev = 1'b1;
          state_d = K_WAIT;
        end else if (hold_q != {HOLD_W{1'b1}}) begin
          hold_d = hold_q + 1'b1;
        end
      end
      K_WAIT: begin
        if (!db[3]) state_d = K_IDLE;
      end
      default: state_d = K_IDLE;
    endcase
  end

  always_comb begin
    speed_d = speed_q;
    mode_d  = mode_q;
    cfg_d   = 1'b0;
    if (short_ev) begin
`ifdef KEY_SPEED_SATURATE_EN
      if (speed_q < SPD_MAX) begin
        speed_d = speed_q + 4'd1;
        cfg_d   = 1'b1;
      end
`else
      speed_d = (speed_q >= SPD_MAX) ? 4'd1 : speed_q + 4'd1;
      cfg_d   = 1'b1;
`endif
    end
    if (long_ev) begin
      case (mode_q)
        3'b000:  mode_d = 3'b001;
        3'b001:  mode_d = 3'b010;
        3'b010:  mode_d = 3'b100;
        default: mode_d = 3'b000;
      endcase
      cfg_d = 1'b1;
`ifdef KEY_SPEED_SATURATE_EN
      speed_d = 4'd1;
`endif
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      db_prev_q <= '0;
      pulse_q   <= '0;
      state_q   <= K_IDLE;
      hold_q    <= '0;
      speed_q   <= 4'd1;
      mode_q    <= '0;
      cfg_q     <= 1'b0;
    end else begin
      db_prev_q <= db_prev_d;
      pulse_q   <= pulse_d;
      state_q   <= state_d;
      hold_q    <= hold_d;
      speed_q   <= speed_d;
      mode_q    <= mode_d;
      cfg_q     <= cfg_d;
    end
  end

  assign o_key_pulse  = pulse_q;
  assign o_speed      = speed_q;
  assign o_fast       = mode_q[0];
  assign o_slow_0     = mode_q[1];
  assign o_slow_1     = mode_q[2];
  assign o_cfg_change = cfg_q;
endmodule

// File: tb/tb_key_command_frontend.sv
// Scoreboard bench for key_command_frontend: stimulus pushes expected events, a monitor pops them.
module tb_key_command_frontend;
  localparam int SPEED_MAX = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] key_n = 4'hF;
  logic [2:0] o_key_pulse;
  logic [3:0] o_speed;
  logic       o_fast, o_slow_0, o_slow_1, o_cfg_change;

  key_command_frontend #(
    .DEBOUNCE_CYCLES  (4),
    .LONGPRESS_CYCLES (20),
    .SPEED_MAX        (SPEED_MAX)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_key_n      (key_n),
    .o_key_pulse  (o_key_pulse),
    .o_speed      (o_speed),
    .o_fast       (o_fast),
    .o_slow_0     (o_slow_0),
    .o_slow_1     (o_slow_1),
    .o_cfg_change (o_cfg_change)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct { int cyc; logic [2:0] val; } pulse_exp_t;
  typedef struct { int cyc; logic [3:0] spd; logic [2:0] mode; } cfg_exp_t;
  pulse_exp_t pq[$];
  cfg_exp_t   cq[$];
  pulse_exp_t pe;
  cfg_exp_t   ce;

  int m_speed = 1;
  int m_mode  = 0;

  function automatic logic [2:0] mode_bits(input int m);
    case (m)
      0:       return 3'b000;
      1:       return 3'b001;
      2:       return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every output event must match the head of its queue, including its cycle.
  always @(negedge clk) begin
    if (o_key_pulse != 3'b000) begin
      if (pq.size() == 0) begin
        check("pulse_unexpected", 32'(o_key_pulse), 32'd0);
      end else begin
        pe = pq.pop_front();
        check("pulse_cycle", cyc, pe.cyc);
        check("pulse_value", 32'(o_key_pulse), 32'(pe.val));
      end
    end
    if (o_cfg_change) begin
      if (cq.size() == 0) begin
        check("cfg_unexpected", 32'(o_cfg_change), 32'd0);
      end else begin
        ce = cq.pop_front();
        check("cfg_cycle", cyc, ce.cyc);
        check("cfg_speed", 32'(o_speed), 32'(ce.spd));
        check("cfg_mode", 32'({o_slow_1, o_slow_0, o_fast}), 32'(ce.mode));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_key(input int k, input logic v, output int t);
    @(negedge clk);
    key_n[k] = v;
    t = cyc;
  endtask

  task automatic push_cfg(input int at);
    cfg_exp_t e;
    e.cyc = at;
    e.spd = 4'(m_speed);
    e.mode = mode_bits(m_mode);
    cq.push_back(e);
  endtask

  task automatic short3();
    int tp, tr;
    set_key(3, 1'b0, tp);
    idle(7);
    set_key(3, 1'b1, tr);
    if (m_speed == SPEED_MAX) begin
`ifndef KEY_SPEED_SATURATE_EN
      m_speed = 1;
      push_cfg(tr + 7);
`endif
    end else begin
      m_speed++;
      push_cfg(tr + 7);
    end
    idle(15);
  endtask

  task automatic long3();
    int tp, tr;
    set_key(3, 1'b0, tp);
    m_mode = (m_mode + 1) % 4;
`ifdef KEY_SPEED_SATURATE_EN
    m_speed = 1;
`endif
    push_cfg(tp + 27);
    idle(59);
    set_key(3, 1'b1, tr);
    idle(15);
  endtask

  initial begin
    int t, t2, r;
    pulse_exp_t p;

    idle(3);
    check("reset_speed", 32'(o_speed), 32'd1);
    check("reset_mode", 32'({o_slow_1, o_slow_0, o_fast}), 32'd0);
    check("reset_pulse", 32'(o_key_pulse), 32'd0);
    check("reset_cfg", 32'(o_cfg_change), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(100);
    check("idle_speed", 32'(o_speed), 32'd1);
    check("idle_mode", 32'({o_slow_1, o_slow_0, o_fast}), 32'd0);

    // 3-cycle glitch on key 0 must be filtered; 10-cycle press gives one pulse.
    set_key(0, 1'b0, t);
    idle(2);
    set_key(0, 1'b1, t2);
    idle(15);
    set_key(0, 1'b0, t);
    p.cyc = t + 7; p.val = 3'b001; pq.push_back(p);
    idle(9);
    set_key(0, 1'b1, t2);
    idle(15);

    // Keys 1 and 2 together.
    @(negedge clk);
    key_n[2:1] = 2'b00;
    t = cyc;
    p.cyc = t + 7; p.val = 3'b110; pq.push_back(p);
    idle(10);
    key_n[2:1] = 2'b11;
    idle(15);

    for (int i = 0; i < 8; i++) short3();
    for (int i = 0; i < 4; i++) long3();

    // Reach SLOW0 at speed 5, then reset in the middle of a hold.
    for (int i = 0; i < 2; i++) long3();
    for (int i = 0; i < 4; i++) short3();
    check("pre_reset_speed", 32'(o_speed), 32'd5);
    check("pre_reset_mode", 32'({o_slow_1, o_slow_0, o_fast}), 32'b010);

    set_key(3, 1'b0, t);
    idle(15);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_speed", 32'(o_speed), 32'd1);
    check("midreset_mode", 32'({o_slow_1, o_slow_0, o_fast}), 32'd0);
    m_speed = 1;
    m_mode  = 0;
    idle(2);
    rst_n = 1'b1;
    r = cyc;
    m_mode = 1;
    push_cfg(r + 27);
    idle(40);
    set_key(3, 1'b1, t2);
    idle(20);

    check("pending_pulse", pq.size(), 32'd0);
    check("pending_cfg", cq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/key_command_frontend.md
Name: key_command_frontend

Overview:
- Pushbutton front end that feeds the recorder/player control FSM.
- Synchronizes and debounces four active-low board keys, then emits one-cycle press pulses for record, play and stop.
- Key 3 is a speed/mode key: a short press steps the speed, a long press cycles the playback mode.
- Outputs connect directly to the control FSM's key inputs and to the DSP speed/mode inputs.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable raw samples required to accept a key level change (10 ms at 50 MHz).
- LONGPRESS_CYCLES, 50000000, debounced hold time on key 3 that counts as a long press (1 s at 50 MHz).
- SPEED_MAX, 8, highest speed value; legal range is 1..SPEED_MAX.

Ports:
- i_clk  input  1  system clock.
- i_rst_n  input  1  asynchronous active-low reset.
- i_key_n  input  4  raw pushbuttons, asynchronous, 0 = pressed; [0] record, [1] play, [2] stop, [3] speed/mode.
- o_key_pulse  output  3  one-cycle press pulses for keys 0..2.
- o_speed  output  4  current speed, 1..SPEED_MAX.
- o_fast  output  1  mode is FAST.
- o_slow_0  output  1  mode is SLOW0 (constant interpolation).
- o_slow_1  output  1  mode is SLOW1 (linear interpolation).
- o_cfg_change  output  1  one-cycle pulse whenever o_speed or mode changes.

Behaviour:
- Clock and reset: one clock, i_clk. Reset is asynchronous and active-low on i_rst_n.
- Reset values: o_key_pulse=0, o_speed=1, mode=NORMAL (o_fast=o_slow_0=o_slow_1=0), o_cfg_change=0. All debounced levels = released; all counters = 0; synchronizer flops = 1 (released).
- Synchronizer: 2-flop synchronizer per key. The block works on the inverted synchronized value, so 1 = pressed.
- Debounce, per key, independent:
  - A counter increments while the synchronized sample differs from the debounced level.
  - It clears to 0 on any cycle the sample equals the debounced level.
  - When the counter reaches DEBOUNCE_CYCLES-1 with a differing sample, the debounced level toggles and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never changes the level.
- Press pulse (keys 0..2):
  - o_key_pulse[k] is high exactly 1 cycle: the cycle after debounced[k] goes 0->1.
  - Release produces nothing.
  - Keys are independent; simultaneous presses give simultaneous pulses.
- Key 3 FSM states:
  - K_IDLE: debounced[3] rises -> K_HOLD, hold counter cleared.
  - K_HOLD: counter increments each cycle.
    - Release before the counter reaches LONGPRESS_CYCLES-1 -> short press, go to K_IDLE.
    - Counter reaching LONGPRESS_CYCLES-1 while held -> long press, go to K_WAIT.
  - K_WAIT: no action; release -> K_IDLE. A long hold fires exactly once.
- Short press: o_speed <= o_speed+1; at SPEED_MAX it wraps to 1. Takes effect the cycle after the release is detected.
- Long press: mode advances NORMAL -> FAST -> SLOW0 -> SLOW1 -> NORMAL. Takes effect the cycle after the threshold is hit.
- o_cfg_change: pulses in the same cycle o_speed or mode updates.
- Mode outputs: exactly one of o_fast/o_slow_0/o_slow_1 is high, or none in NORMAL. They are registered with no glitches.
- Widths: hold counter is sized by $clog2(LONGPRESS_CYCLES) and saturates, so it cannot wrap. Debounce counter is sized by $clog2(DEBOUNCE_CYCLES).
- Reset mid-operation: all state returns to reset values immediately. A key held across reset deassertion must be re-debounced and then produces a press (pulse or K_HOLD entry). Intended, documented.
- Speed register is never 0 and never above SPEED_MAX.

Optional Feature:
- Macro: KEY_SPEED_SATURATE_EN.
- Defined:
  - A short press at o_speed=SPEED_MAX leaves it at SPEED_MAX; no o_cfg_change pulse.
  - Every long-press mode change also resets o_speed to 1.
- Undefined: speed wraps SPEED_MAX -> 1, and mode changes leave o_speed untouched.

Test Plan:
- Bench parameters: DEBOUNCE_CYCLES=4, LONGPRESS_CYCLES=20.
- Reset, all keys released -> o_speed=1, mode outputs 000, no pulses for 100 cycles.
- i_key_n[0] low for 3 cycles then high; then low for 10 cycles -> no pulse for the 3-cycle glitch; exactly one o_key_pulse[0] pulse for the 10-cycle press, 2+4+1 cycles after the press edge; no pulse on release.
- Keys 1 and 2 pressed in the same cycle for 10 cycles -> o_key_pulse = 3'b110 for exactly one cycle.
- Key 3 pressed 8 cycles, released, repeated 8 times -> o_speed steps 2,3,...,8 then 1 (macro undefined) or stays 8 (macro defined); o_cfg_change pulse count 8 (undefined) or 7 (defined).
- Key 3 held 60 cycles, four times -> o_fast, o_slow_0, o_slow_1, then NORMAL in turn; one change per hold; no speed change on release.
- i_rst_n asserted during a K_HOLD with o_speed=5 and mode SLOW0 -> outputs immediately return to o_speed=1, mode 000; key still held after reset -> enters K_HOLD again after debounce.
